// File: rtl/trap_ctrl.sv
// ============================================================================
// trap_ctrl : machine-mode trap/mret controller with the trap CSRs and a
//             one-cycle registered fetch redirect.   Revision 1.0
// ============================================================================
`default_nettype none

package CsrPack;
   typedef struct packed {
      logic        except;
      logic [63:0] epc;
      logic [63:0] ecause;
      logic [63:0] etval;
   } ExceptPack;
endpackage

module trap_ctrl (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  CsrPack::ExceptPack except_i,
   input  logic               mret,
   input  logic               csr_we,
   input  logic [11:0]        csr_addr,
   input  logic [63:0]        csr_wdata,
   output logic [63:0]        csr_rdata,
   output logic               redirect_valid,
   output logic [63:0]        redirect_pc,
   output logic               flush_o
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MTVAL    = 12'h343;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic        mie_q, mie_d;
   logic        mpie_q, mpie_d;
   logic [63:0] mtvec_q, mtvec_d;
   logic [63:0] mscratch_q, mscratch_d;
   logic [63:0] mepc_q, mepc_d;
   logic [63:0] mcause_q, mcause_d;
   logic [63:0] mtval_q, mtval_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [63:0] redirect_pc_q, redirect_pc_d;

   logic        accept_ok;
   logic        take_trap;
   logic        take_mret;
   logic        do_write;
   logic [63:0] trap_base;
   logic [63:0] trap_offset;
   logic [63:0] trap_target;

   // Events are only accepted from IDLE; a trap suppresses mret and CSR writes.
   assign accept_ok = (state_q == IDLE) && !stall;
   assign take_trap = accept_ok && except_i.except;
   assign take_mret = accept_ok && mret && !except_i.except;
   assign do_write  = accept_ok && csr_we && !except_i.except;

   // Vectored mode only applies to interrupts (ecause[63] set).
   assign trap_base   = {mtvec_q[63:2], 2'b00};
   assign trap_offset = (mtvec_q[0] && except_i.ecause[63]) ?
                        {except_i.ecause[61:0], 2'b00} : 64'd0;
   assign trap_target = trap_base + trap_offset;

   always_comb begin
      state_d          = IDLE;
      mie_d            = mie_q;
      mpie_d           = mpie_q;
      mtvec_d          = mtvec_q;
      mscratch_d       = mscratch_q;
      mepc_d           = mepc_q;
      mcause_d         = mcause_q;
      mtval_d          = mtval_q;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;

      if (do_write) begin
         case (csr_addr)
            ADDR_MSTATUS: begin
               if (!take_mret) begin
                  mie_d  = csr_wdata[3];
                  mpie_d = csr_wdata[7];
               end
            end
            ADDR_MTVEC:    mtvec_d    = {csr_wdata[63:2], 1'b0, csr_wdata[0]};
            ADDR_MSCRATCH: mscratch_d = csr_wdata;
            ADDR_MEPC:     mepc_d     = csr_wdata & ~64'd3;
            ADDR_MCAUSE:   mcause_d   = csr_wdata;
            ADDR_MTVAL:    mtval_d    = csr_wdata;
            default:       ;
         endcase
      end

      if (take_trap) begin
         mepc_d           = except_i.epc & ~64'd3;
         mcause_d         = except_i.ecause;
         mtval_d          = except_i.etval;
         mpie_d           = mie_q;
         mie_d            = 1'b0;
         redirect_pc_d    = trap_target;
         redirect_valid_d = 1'b1;
         state_d          = REDIRECT;
      end else if (take_mret) begin
         mie_d            = mpie_q;
         mpie_d           = 1'b1;
         redirect_pc_d    = mepc_q;
         redirect_valid_d = 1'b1;
         state_d          = REDIRECT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         mie_q            <= 1'b0;
         mpie_q           <= 1'b0;
         mtvec_q          <= 64'd0;
         mscratch_q       <= 64'd0;
         mepc_q           <= 64'd0;
         mcause_q         <= 64'd0;
         mtval_q          <= 64'd0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 64'd0;
      end else begin
         state_q          <= state_d;
         mie_q            <= mie_d;
         mpie_q           <= mpie_d;
         mtvec_q          <= mtvec_d;
         mscratch_q       <= mscratch_d;
         mepc_q           <= mepc_d;
         mcause_q         <= mcause_d;
         mtval_q          <= mtval_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   always_comb begin
      csr_rdata = 64'd0;
      case (csr_addr)
         ADDR_MSTATUS: begin
            csr_rdata[3]     = mie_q;
            csr_rdata[7]     = mpie_q;
            csr_rdata[12:11] = 2'b11;
         end
         ADDR_MTVEC:    csr_rdata = mtvec_q;
         ADDR_MSCRATCH: csr_rdata = mscratch_q;
         ADDR_MEPC:     csr_rdata = mepc_q;
         ADDR_MCAUSE:   csr_rdata = mcause_q;
         ADDR_MTVAL:    csr_rdata = mtval_q;
         default:       csr_rdata = 64'd0;
      endcase
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign flush_o        = redirect_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
// tb_trap_ctrl : directed + randomized bench for trap_ctrl against a
//                behavioural CSR/redirect model.   Revision 1.0
// ============================================================================
`default_nettype none

module tb_trap_ctrl;

   logic               clk;
   logic               rst;
   logic               stall;
   CsrPack::ExceptPack except_i;
   logic               mret;
   logic               csr_we;
   logic [11:0]        csr_addr;
   logic [63:0]        csr_wdata;
   logic [63:0]        csr_rdata;
   logic               redirect_valid;
   logic [63:0]        redirect_pc;
   logic               flush_o;

   trap_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .except_i       (except_i),
      .mret           (mret),
      .csr_we         (csr_we),
      .csr_addr       (csr_addr),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush_o        (flush_o)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Stimulus for the next cycle
   logic        d_rst, d_stall, d_exc, d_mret, d_we;
   logic [63:0] d_epc, d_ecause, d_etval, d_wdata;
   logic [11:0] d_addr;

   // Reference model state: architectural CSR values as software sees them
   logic [63:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   logic        m_busy;
   logic        m_rv;
   logic [63:0] m_rpc;

   logic [11:0] read_addrs [7];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [63:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         default: return 64'd0;
      endcase
   endfunction

   task automatic model_step();
      logic [63:0] old_mstatus, old_mepc, tgt;
      if (d_rst) begin
         m_mstatus = 64'h1800; m_mtvec = 0; m_mscratch = 0;
         m_mepc = 0; m_mcause = 0; m_mtval = 0;
         m_busy = 0; m_rv = 0; m_rpc = 0;
      end else if (m_busy) begin
         m_busy = 0; m_rv = 0;
      end else if (d_stall) begin
         m_rv = 0;
      end else if (d_exc) begin
         tgt = m_mtvec & ~64'd3;
         if (m_mtvec[0] && d_ecause[63]) tgt = tgt + d_ecause * 4;
         m_mepc    = d_epc & ~64'd3;
         m_mcause  = d_ecause;
         m_mtval   = d_etval;
         m_mstatus = 64'h1800 | (m_mstatus[3] ? 64'h80 : 64'h0);
         m_rpc = tgt; m_rv = 1; m_busy = 1;
      end else begin
         old_mstatus = m_mstatus;
         old_mepc    = m_mepc;
         if (d_we) begin
            case (d_addr)
               12'h300: m_mstatus = (d_wdata & 64'h88) | 64'h1800;
               12'h305: m_mtvec    = d_wdata & ~64'd2;
               12'h340: m_mscratch = d_wdata;
               12'h341: m_mepc     = d_wdata & ~64'd3;
               12'h342: m_mcause   = d_wdata;
               12'h343: m_mtval    = d_wdata;
               default: ;
            endcase
         end
         if (d_mret) begin
            m_mstatus = 64'h1880 | (old_mstatus[7] ? 64'h8 : 64'h0);
            m_rpc = old_mepc; m_rv = 1; m_busy = 1;
         end else begin
            m_rv = 0;
         end
      end
   endtask

   task automatic idle();
      d_rst = 0; d_stall = 0; d_exc = 0; d_mret = 0; d_we = 0;
      d_epc = 0; d_ecause = 0; d_etval = 0; d_wdata = 0; d_addr = 0;
   endtask

   task automatic read_chk(input string tag, input logic [11:0] a, input logic [63:0] exp);
      csr_addr = a;
      #1;
      check(tag, csr_rdata, exp);
   endtask

   task automatic cycle();
      @(negedge clk);
      rst = d_rst; stall = d_stall; mret = d_mret; csr_we = d_we;
      csr_addr = d_addr; csr_wdata = d_wdata;
      except_i.except = d_exc; except_i.epc = d_epc;
      except_i.ecause = d_ecause; except_i.etval = d_etval;
      @(posedge clk);
      model_step();
      #1;
      check("redirect_valid", {63'd0, redirect_valid}, {63'd0, m_rv});
      check("flush_o", {63'd0, flush_o}, {63'd0, m_rv});
      check("redirect_pc", redirect_pc, m_rpc);
      foreach (read_addrs[k]) read_chk($sformatf("csr_%h", read_addrs[k]), read_addrs[k], m_read(read_addrs[k]));
   endtask

   initial begin
      read_addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344};
      rst = 1; stall = 0; mret = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
      except_i = '0;
      m_mstatus = 64'h1800; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
      m_mcause = 0; m_mtval = 0; m_busy = 0; m_rv = 0; m_rpc = 0;

      idle(); d_rst = 1; cycle(); cycle();
      read_chk("rst_mstatus", 12'h300, 64'h1800);

      // Basic direct-mode trap
      idle(); d_we = 1; d_addr = 12'h305; d_wdata = 64'h8000_0100; cycle();
      idle(); d_we = 1; d_addr = 12'h300; d_wdata = 64'h8; cycle();
      idle(); d_exc = 1; d_epc = 64'h8000_0042; d_ecause = 2; d_etval = 64'hDEAD; cycle();
      check("t1_rv", {63'd0, redirect_valid}, 64'd1);
      check("t1_pc", redirect_pc, 64'h8000_0100);
      read_chk("t1_mepc", 12'h341, 64'h8000_0040);
      read_chk("t1_mcause", 12'h342, 64'd2);
      read_chk("t1_mstatus", 12'h300, 64'h1880);
      idle(); cycle();
      check("t1_rv_drop", {63'd0, redirect_valid}, 64'd0);
      read_chk("t1_mtval", 12'h343, 64'hDEAD);

      // Vectored interrupt
      idle(); d_we = 1; d_addr = 12'h305; d_wdata = 64'h8000_0101; cycle();
      idle(); d_exc = 1; d_epc = 64'h8000_0040; d_ecause = 64'h8000_0000_0000_0007; cycle();
      check("t2_pc", redirect_pc, 64'h8000_011C);
      idle(); cycle();

      // mret
      idle(); d_we = 1; d_addr = 12'h300; d_wdata = 64'h80; cycle();
      idle(); d_mret = 1; cycle();
      check("t3_rv", {63'd0, redirect_valid}, 64'd1);
      check("t3_pc", redirect_pc, 64'h8000_0040);
      read_chk("t3_mstatus", 12'h300, 64'h1888);
      idle(); cycle();

      // Trap beats a simultaneous mret and CSR write
      idle(); d_we = 1; d_addr = 12'h340; d_wdata = 64'h77; cycle();
      idle(); d_exc = 1; d_epc = 64'h1000; d_ecause = 3; d_mret = 1;
      d_we = 1; d_addr = 12'h340; d_wdata = 64'd5; cycle();
      check("t4_pc", redirect_pc, 64'h8000_0100);
      read_chk("t4_mscratch", 12'h340, 64'h77);
      read_chk("t4_mstatus", 12'h300, 64'h1880);
      idle(); cycle();

      // Held exception under stall
      for (int s = 0; s < 3; s++) begin
         idle(); d_stall = 1; d_exc = 1; d_epc = 64'h2004; d_ecause = 5; d_etval = 64'h55; cycle();
         check("t5_stall_rv", {63'd0, redirect_valid}, 64'd0);
      end
      idle(); d_exc = 1; d_epc = 64'h2004; d_ecause = 5; d_etval = 64'h55; cycle();
      check("t5_rv", {63'd0, redirect_valid}, 64'd1);
      read_chk("t5_mcause", 12'h342, 64'd5);
      idle(); d_exc = 1; d_epc = 64'h2004; d_ecause = 5; d_etval = 64'h55; cycle();
      check("t5_ignored", {63'd0, redirect_valid}, 64'd0);

      // Back-to-back trap, then reset while redirecting
      idle(); d_exc = 1; d_epc = 64'h3000; d_ecause = 8; cycle();
      check("t6_rv", {63'd0, redirect_valid}, 64'd1);
      read_chk("t6_mepc", 12'h341, 64'h3000);
      idle(); d_rst = 1; d_exc = 1; cycle();
      check("t7_rv", {63'd0, redirect_valid}, 64'd0);
      read_chk("t7_mstatus", 12'h300, 64'h1800);
      read_chk("t7_mtvec", 12'h305, 64'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         idle();
         d_rst   = ($urandom_range(0, 39) == 0);
         d_stall = ($urandom_range(0, 3) == 0);
         d_exc   = ($urandom_range(0, 4) == 0);
         d_mret  = ($urandom_range(0, 4) == 0);
         d_we    = ($urandom_range(0, 1) == 1);
         d_addr  = read_addrs[$urandom_range(0, 6)];
         d_wdata = {$urandom, $urandom};
         d_epc   = {$urandom, $urandom};
         d_ecause = {$urandom_range(0, 1) == 1, 58'd0, 5'($urandom_range(0, 31))};
         d_etval = {$urandom, $urandom};
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on posedge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port stall, input, 1 bit: when 1, no trap, mret or CSR write is accepted this cycle.
REQ-004 SHALL have port except_i, input, CsrPack::ExceptPack: {except, epc[63:0], ecause[63:0], etval[63:0]} from the MEM/WB exception register.
REQ-005 SHALL have port mret, input, 1 bit: an mret instruction is at commit.
REQ-006 SHALL have ports csr_we (input, 1), csr_addr (input, 12), csr_wdata (input, 64) and csr_rdata (output, 64): single CSR access port.
REQ-007 SHALL have ports redirect_valid (output, 1) and redirect_pc (output, 64): fetch redirect, both registered.
REQ-008 SHALL have port flush_o, output, 1 bit: pipeline flush, equal to redirect_valid.

Function
REQ-009 SHALL hold CSRs mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342 and mtval 0x343, all 64 bits.
REQ-010 SHALL implement only MIE (bit 3), MPIE (bit 7) and MPP (bits 12:11) in mstatus; MPP SHALL read 2'b11, and all other mstatus bits SHALL read 0 and ignore writes.
REQ-011 SHALL force mepc[1:0] to 0 on every write, and SHALL force mtvec[1] to 0 on every write.
REQ-012 SHALL drive csr_rdata combinationally from csr_addr; unmapped addresses SHALL read 0 and ignore writes.
REQ-013 SHALL implement an FSM with states IDLE and REDIRECT, with state reset to IDLE.
REQ-014 SHALL accept a trap when state=IDLE, stall=0 and except_i.except=1; at that edge: mepc<=epc (bits 1:0 cleared), mcause<=ecause, mtval<=etval, MPIE<=MIE, MIE<=0, state<=REDIRECT.
REQ-015 SHALL compute the trap target as mtvec base (mtvec with bits 1:0 cleared).
REQ-016 SHALL additionally add 4*ecause[62:0] to the trap target when mtvec[0]=1 and ecause[63]=1.
REQ-017 SHALL accept an mret when state=IDLE, stall=0, mret=1 and except_i.except=0; at that edge: MIE<=MPIE, MPIE<=1, redirect_pc<=mepc, state<=REDIRECT.
REQ-018 SHALL give a trap priority over a simultaneous mret, in which case the mret has no effect.
REQ-019 SHALL give a trap priority over a simultaneous CSR write, in which case the write is dropped.
REQ-020 SHALL let a CSR write coincident with an accepted mret take effect, except that mstatus written in the same cycle takes the mret update.
REQ-021 SHALL have a fixed latency: for an event accepted at edge N, redirect_valid=1 and flush_o=1 for exactly the one cycle after edge N, with redirect_pc stable during that cycle.
REQ-022 SHALL ignore except_i, mret and csr_we in REDIRECT, since those instructions are being flushed, and SHALL return unconditionally to IDLE at the next edge even if stall=1.
REQ-023 SHALL, when stall=1 in IDLE, change no CSR and no state, so that a held exception is taken on the first unstalled cycle.
REQ-024 SHALL be back-to-back capable: a trap accepted in the first IDLE cycle after REDIRECT yields a second one-cycle redirect.

Reset
REQ-025 SHALL, on rst=1 at a posedge, clear all CSRs to 0 (MPP still reads 2'b11), set state to IDLE, and clear redirect_valid, flush_o and redirect_pc to 0.
REQ-026 SHALL give rst priority over everything, including a trap or mret in the same cycle or a reset during REDIRECT, which SHALL drop redirect_valid at the next edge.

Verification
REQ-027 SHALL check: write mtvec=0x8000_0100 with MIE=1, then except={1, epc 0x8000_0042, ecause 2, etval 0xDEAD} -> next cycle redirect_pc=0x8000_0100, redirect_valid=1 for one cycle, mepc=0x8000_0040, mcause=2, mtval=0xDEAD, MIE=0, MPIE=1.
REQ-028 SHALL check: mtvec=0x8000_0101 with ecause=0x8000_0000_0000_0007 -> redirect_pc=0x8000_011C.
REQ-029 SHALL check: mret with mepc=0x8000_0040 and MPIE=1 -> redirect_pc=0x8000_0040, MIE=1, MPIE=1.
REQ-030 SHALL check: except and mret asserted together, with csr_we to mscratch=5 -> trap taken, mscratch unchanged, MIE cleared.
REQ-031 SHALL check: except held with stall=1 for 3 cycles, then stall=0 -> no redirect during the stall, exactly one redirect after it, CSRs updated once.
REQ-032 SHALL check: rst asserted during REDIRECT -> redirect_valid=0 and all CSRs 0 after the edge; a read of mstatus returns 0x1800.
